// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster timing bundle from the timing generator to its consumers.
//   master : timing generator (drives everything)
//   slave  : painting stage / VGA connector (observes everything)
//   Signals:
//     cur_x, cur_y  scan position
//     hsync, vsync  sync pulses at the configured polarity
//     video_on      position lies inside the visible window
//     pix_tick      pixel enable
//     line_start    position is the first pixel of a line
//     frame_start   position is the first pixel of a frame
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_tick;
    logic       line_start;
    logic       frame_start;

    modport master (
        output cur_x, cur_y, hsync, vsync, video_on, pix_tick,
               line_start, frame_start
    );

    modport slave (
        input  cur_x, cur_y, hsync, vsync, video_on, pix_tick,
               line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Free-running raster timing generator (default 640x480@60, 25 MHz pixels).
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous reset, active low
//     vga    vga_timing_gen_if.master: cur_x, cur_y, hsync, vsync, video_on,
//            pix_tick, line_start, frame_start (all registered)
//   Build option:
//     VGA_CLK_DIV2_EN  defined   -> pix_tick toggles, one pixel per 2 clks
//                      undefined -> pix_tick held 1, one pixel per clk
//   Every decoded output is computed from the *next* position and registered
//   together with it, so sync/blank/markers never skew against cur_x/cur_y.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide; larger rasters cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
        end
    endgenerate

    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    // Window bounds kept 11 bits wide so a bound of exactly 1024 still works.
    localparam logic [10:0] X_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] Y_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_STOP  = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_STOP  = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic        HS_ACT   = (HS_POL != 0);
    localparam logic        VS_ACT   = (VS_POL != 0);

    logic [9:0] cur_x_q, cur_y_q;
    logic       hsync_q, vsync_q, video_on_q, tick_q, line_q, frame_q;

    // Next position, used both to advance and to pre-decode the outputs.
    logic [9:0]  nx, ny;
    logic [10:0] nx_w, ny_w;

    always_comb begin
        nx = cur_x_q + 10'd1;
        ny = cur_y_q;
        if (cur_x_q == X_LAST) begin
            nx = 10'd0;
            ny = (cur_y_q == Y_LAST) ? 10'd0 : cur_y_q + 10'd1;
        end
        nx_w = {1'b0, nx};
        ny_w = {1'b0, ny};
    end

    // Reset parks the raster at the last position with outputs that describe
    // it, so the first advance lands cleanly on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x_q    <= X_LAST;
            cur_y_q    <= Y_LAST;
            tick_q     <= 1'b0;
            hsync_q    <= ~HS_ACT;
            vsync_q    <= ~VS_ACT;
            video_on_q <= 1'b0;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
`ifdef VGA_CLK_DIV2_EN
            tick_q <= ~tick_q;
`else
            tick_q <= 1'b1;
`endif
            if (tick_q) begin
                cur_x_q    <= nx;
                cur_y_q    <= ny;
                hsync_q    <= (nx_w >= HS_START && nx_w < HS_STOP) ? HS_ACT : ~HS_ACT;
                vsync_q    <= (ny_w >= VS_START && ny_w < VS_STOP) ? VS_ACT : ~VS_ACT;
                video_on_q <= (nx_w < X_VIS) && (ny_w < Y_VIS);
                line_q     <= (nx == 10'd0);
                frame_q    <= (nx == 10'd0) && (ny == 10'd0);
            end
        end
    end

    assign vga.cur_x       = cur_x_q;
    assign vga.cur_y       = cur_y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pix_tick    = tick_q;
    assign vga.line_start  = line_q;
    assign vga.frame_start = frame_q;

endmodule
